// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// capture into a small instruction buffer, and redirect flush with drop count.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] infl_q, infl_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] occ_q, occ_d;

  logic [31:0]   fpc_q [DEPTH];
  logic [31:0]   fpc_d [DEPTH];
  logic [31:0]   fwd_q [DEPTH];
  logic [31:0]   fwd_d [DEPTH];
  logic [PW-1:0] f_rd_q, f_rd_d;
  logic [PW-1:0] f_wr_q, f_wr_d;

  logic [31:0]   pq_q [DEPTH];
  logic [31:0]   pq_d [DEPTH];
  logic [PW-1:0] q_rd_q, q_rd_d;
  logic [PW-1:0] q_wr_q, q_wr_d;

  logic          req_ok;
  logic          acc;
  logic          rsp_ok;
  logic          keep;
  logic          pop;
  logic [CW:0]   credit;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign credit = {1'b0, infl_q} + {1'b0, occ_q};
  assign req_ok = !rst && !redirect_valid &&
                  (credit < (CW + 1)'(DEPTH));
  assign acc    = req_ok && imem_req_ready;
  assign rsp_ok = imem_rsp_valid && (infl_q != '0);
  assign keep   = rsp_ok && !redirect_valid && (drop_q == '0);
  assign pop    = instr_valid && instr_ready;

  assign imem_req_valid = req_ok;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = (occ_q != '0);
  assign instr          = instr_valid ? fwd_q[f_rd_q] : 32'h0;
  assign instr_pc       = instr_valid ? fpc_q[f_rd_q] : 32'h0;

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    fpc_d  = fpc_q;
    fwd_d  = fwd_q;
    f_rd_d = f_rd_q;
    f_wr_d = f_wr_q;
    pq_d   = pq_q;
    q_rd_d = q_rd_q;
    q_wr_d = q_wr_q;
    infl_d = infl_q + CW'(acc) - CW'(rsp_ok);
    occ_d  = occ_q + CW'(keep) - CW'(pop);
    if (acc) begin
      pc_d         = pc_q + 32'd4;
      pq_d[q_wr_q] = pc_q;
      q_wr_d       = nxt(q_wr_q);
    end
    if (rsp_ok) begin
      q_rd_d = nxt(q_rd_q);
      if (!keep && drop_q != '0)
        drop_d = drop_q - CW'(1);
    end
    if (keep) begin
      fpc_d[f_wr_q] = pq_q[q_rd_q];
      fwd_d[f_wr_q] = imem_rsp_data;
      f_wr_d        = nxt(f_wr_q);
    end
    if (pop)
      f_rd_d = nxt(f_rd_q);
    // Everything still outstanding after this edge belongs to the old path.
    if (redirect_valid) begin
      pc_d   = {redirect_pc[31:2], 2'b00};
      f_rd_d = '0;
      f_wr_d = '0;
      occ_d  = '0;
      drop_d = infl_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      infl_q <= '0;
      drop_q <= '0;
      occ_q  <= '0;
      f_rd_q <= '0;
      f_wr_q <= '0;
      q_rd_q <= '0;
      q_wr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fpc_q[i] <= '0;
        fwd_q[i] <= '0;
        pq_q[i]  <= '0;
      end
    end else begin
      pc_q   <= pc_d;
      infl_q <= infl_d;
      drop_q <= drop_d;
      occ_q  <= occ_d;
      f_rd_q <= f_rd_d;
      f_wr_q <= f_wr_d;
      q_rd_q <= q_rd_d;
      q_wr_q <= q_wr_d;
      fpc_q  <= fpc_d;
      fwd_q  <= fwd_d;
      pq_q   <= pq_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: epoch-tagged memory model feeding a
// scoreboard of expected deliveries, checked by an independent monitor.
module tb_fetch_stage;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  fetch_stage #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          ep;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } ins_t;

  req_t        memq[$];
  ins_t        sb[$];
  int          epoch;
  logic [31:0] model_pc;
  logic        rsp_live;
  logic [31:0] rsp_pc;
  int          rsp_ep;
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic rst_checks();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
  endtask

  task automatic do_reset(input bit mid);
    if (mid) begin
      @(posedge clk);
      #2;
    end
    rst = 1'b1;
    #1;
    rst_checks();
    chk("rst_pc", imem_req_addr, RPC);
    memq.delete();
    sb.delete();
    epoch++;
    model_pc       = RPC;
    rsp_live       = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    imem_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // A late response from before reset; the block has nothing in flight.
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
  endtask

  task automatic drive(input logic rv, input logic [31:0] rpc,
                       input logic rqr, input logic rspv,
                       input logic ir);
    req_t e;
    @(posedge clk);
    #1;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = rqr;
    instr_ready    = ir;
    if (rspv && memq.size() > 0) begin
      e              = memq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(e.addr);
      rsp_pc         = e.addr;
      rsp_ep         = e.ep;
      rsp_live       = 1'b1;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      rsp_live       = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    int   infl;
    logic erv;
    ins_t h;
    if (!rst) begin
      infl = memq.size() + (rsp_live ? 1 : 0);
      erv  = !redirect_valid && ((infl + sb.size()) < DEPTH);
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, erv});
      if (imem_req_valid)
        chk("req_addr", imem_req_addr, model_pc);
      chk("instr_valid", {31'b0, instr_valid},
          {31'b0, sb.size() != 0});
      if (sb.size() != 0) begin
        h = sb[0];
        chk("instr_pc", instr_pc, h.pc);
        chk("instr", instr, h.w);
        if (instr_valid && instr_ready)
          void'(sb.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        memq.push_back('{addr: model_pc, ep: epoch});
        model_pc = model_pc + 32'd4;
      end
      if (rsp_live && !redirect_valid && rsp_ep == epoch)
        sb.push_back('{pc: rsp_pc, w: mem_word(rsp_pc)});
      if (redirect_valid) begin
        sb.delete();
        epoch++;
        model_pc = redirect_pc & 32'hFFFF_FFFC;
      end
    end
  end

  initial begin
    checks         = 0;
    errors         = 0;
    epoch          = 0;
    rsp_live       = 1'b0;
    rsp_pc         = '0;
    rsp_ep         = 0;
    redirect_pc    = '0;
    imem_rsp_data  = '0;
    do_reset(1'b0);

    repeat (12) drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    repeat (10) drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    repeat (6)  drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    repeat (5)  drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 32'h0000_1002, 1'b1, 1'b0, 1'b1);
    repeat (10) drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    repeat (4)  drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_2000, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 32'h0000_3005, 1'b1, 1'b1, 1'b1);
    repeat (10) drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    repeat (5)  drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    do_reset(1'b1);
    repeat (10) drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      r = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF6 : $urandom;
      if (i == 1500) do_reset(1'b1);
      drive(($urandom_range(0, 19) == 0), r,
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 2) != 0));
    end
    repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
